// File: rtl/mc_controller_p.sv
// mc_controller_p: multicycle controller for the accumulator/register datapath.
// It sequences fetch, decode and execute, and stretches every memory access
// until the memory reports completion. If a memory access waits longer than
// WAIT_MAX cycles, the controller parks in a sticky FAULT state until reset.
module mc_controller_p #(
   parameter int IW       = 8,
   parameter int AOPW     = 2,
   parameter int WAIT_MAX = 15
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [IW-1:0]   ins,
   input  logic [2:0]      czn,
   input  logic            mem_ready,
   output logic            selA,
   output logic            selB,
   output logic            IorD,
   output logic            memRead,
   output logic            memWrite,
   output logic            pcWrite,
   output logic            IRld,
   output logic            TRld,
   output logic            MDRld,
   output logic            DIld,
   output logic            CZNld,
   output logic            regWrite,
   output logic            RA2sel,
   output logic            WAsel,
   output logic            WDsel,
   output logic            jmpSignal,
   output logic [AOPW-1:0] aluOp,
   output logic            fault,
   output logic [3:0]      state_o
);

   localparam logic [3:0] S_IF    = 4'd0;
   localparam logic [3:0] S_ID    = 4'd1;
   localparam logic [3:0] S_JMP   = 4'd2;
   localparam logic [3:0] S_ACU   = 4'd3;
   localparam logic [3:0] S_LW1   = 4'd4;
   localparam logic [3:0] S_LW2   = 4'd5;
   localparam logic [3:0] S_AD1   = 4'd6;
   localparam logic [3:0] S_AD2   = 4'd7;
   localparam logic [3:0] S_SW    = 4'd8;
   localparam logic [3:0] S_DI    = 4'd9;
   localparam logic [3:0] S_FAULT = 4'd15;

   localparam logic [AOPW-1:0] ALU_ADD = AOPW'(0);
   localparam logic [AOPW-1:0] ALU_AND = AOPW'(1);
   localparam logic [AOPW-1:0] ALU_OR  = AOPW'(2);

   // The counter only has to reach WAIT_MAX; it saturates beyond that, so a
   // disabled timeout (WAIT_MAX=0) cannot wrap into anything meaningful.
   localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

   logic [3:0]    state_q, state_d;
   logic [CW-1:0] wcnt_q, wcnt_d;

   logic [2:0] op;
   logic [1:0] fld;
   logic [1:0] cc;
   logic       is_mem;
   logic       timeout;
   logic       jmp_taken;
   logic       st_known;
   logic       unused_ins;

   assign op  = ins[IW-1:IW-3];
   assign fld = ins[IW-3:IW-4];
   assign cc  = ins[IW-4:IW-5];

   // Low instruction bits carry operand fields for the datapath only.
   assign unused_ins = ^ins[IW-6:0];

   assign is_mem = (state_q == S_IF) || (state_q == S_LW1) ||
                   (state_q == S_AD1) || (state_q == S_SW);

   // A completing access (mem_ready=1) always wins over the timeout.
   assign timeout = (WAIT_MAX > 0) && is_mem && !mem_ready &&
                    (wcnt_q == CW'(WAIT_MAX));

   assign st_known = (state_q <= S_DI) || (state_q == S_FAULT);

   // Jump condition: unconditional, or on C, Z or N from the CZN register.
   always_comb begin
      jmp_taken = 1'b0;
      case (cc)
         2'b00:   jmp_taken = 1'b1;
         2'b01:   jmp_taken = czn[2];
         2'b10:   jmp_taken = czn[1];
         default: jmp_taken = czn[0];
      endcase
   end

   // State and wait-counter registers; reset lands in IF with a clear counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IF;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
      end
   end

   // Next-state logic: memory states hold until mem_ready or timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IF: begin
            if (mem_ready)    state_d = S_ID;
            else if (timeout) state_d = S_FAULT;
         end
         S_ID: begin
            case (op)
               3'b000:          state_d = S_LW1;
               3'b001:          state_d = S_SW;
               3'b010, 3'b011:  state_d = S_AD1;
               3'b100, 3'b101:  state_d = S_ACU;
               3'b110:          state_d = S_JMP;
               default:         state_d = S_DI;
            endcase
         end
         S_JMP:   state_d = S_IF;
         S_ACU:   state_d = S_IF;
         S_LW1: begin
            if (mem_ready)    state_d = S_LW2;
            else if (timeout) state_d = S_FAULT;
         end
         S_LW2:   state_d = S_IF;
         S_AD1: begin
            if (mem_ready)    state_d = S_AD2;
            else if (timeout) state_d = S_FAULT;
         end
         S_AD2:   state_d = S_IF;
         S_SW: begin
            if (mem_ready)    state_d = S_IF;
            else if (timeout) state_d = S_FAULT;
         end
         S_DI:    state_d = S_IF;
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_IF;
      endcase
   end

   // Wait counter: counts stalled cycles of the current access, restarts on any state change.
   always_comb begin
      wcnt_d = wcnt_q;
      if (state_d != state_q) begin
         wcnt_d = '0;
      end else if (is_mem && !mem_ready && (wcnt_q != {CW{1'b1}})) begin
         wcnt_d = wcnt_q + CW'(1);
      end
   end

   // Output decode: strobes per state; everything forced low while rst is high.
   always_comb begin
      selA      = 1'b0;
      selB      = 1'b0;
      IorD      = 1'b0;
      memRead   = 1'b0;
      memWrite  = 1'b0;
      pcWrite   = 1'b0;
      IRld      = 1'b0;
      TRld      = 1'b0;
      MDRld     = 1'b0;
      DIld      = 1'b0;
      CZNld     = 1'b0;
      regWrite  = 1'b0;
      RA2sel    = 1'b0;
      WAsel     = 1'b0;
      WDsel     = 1'b0;
      jmpSignal = 1'b0;
      aluOp     = ALU_ADD;
      fault     = 1'b0;
      state_o   = 4'd0;
      if (!rst) begin
         if (st_known) state_o = state_q;
         case (state_q)
            S_IF: begin
               memRead = 1'b1;
               IRld    = mem_ready;
               pcWrite = mem_ready;
            end
            S_ID: begin
               TRld = (op == 3'b000) || (op == 3'b001) || (op == 3'b010) ||
                      (op == 3'b011) || (op == 3'b110);
            end
            S_JMP: begin
               jmpSignal = jmp_taken;
               pcWrite   = jmp_taken;
            end
            S_ACU: begin
               selB     = 1'b1;
               WDsel    = 1'b1;
               regWrite = 1'b1;
               CZNld    = 1'b1;
               case (fld)
                  2'b00:   begin selA = 1'b1; aluOp = ALU_ADD; end
                  2'b01:   aluOp = ALU_ADD;
                  2'b10:   aluOp = ALU_AND;
                  default: aluOp = ALU_OR;
               endcase
            end
            S_LW1: begin
               IorD    = 1'b1;
               memRead = 1'b1;
               MDRld   = mem_ready;
            end
            S_LW2: begin
               RA2sel   = 1'b1;
               WAsel    = 1'b1;
               regWrite = 1'b1;
            end
            S_AD1: begin
               IorD    = 1'b1;
               memRead = 1'b1;
               MDRld   = mem_ready;
            end
            S_AD2: begin
               RA2sel   = 1'b1;
               WAsel    = 1'b1;
               WDsel    = 1'b1;
               regWrite = 1'b1;
               CZNld    = 1'b1;
               aluOp    = ins[IW-3] ? ALU_AND : ALU_ADD;
            end
            S_SW: begin
               IorD     = 1'b1;
               selB     = 1'b1;
               memWrite = 1'b1;
            end
            S_DI: begin
               DIld = 1'b1;
            end
            S_FAULT: begin
               fault = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_controller_p.sv
// Bench for mc_controller_p: directed scenarios plus random instruction
// streams, checked cycle by cycle against an instruction-level model.
module tb_mc_controller_p;

   localparam int IW   = 8;
   localparam int AOPW = 2;
   localparam int WM   = 3;

   localparam logic [15:0] B_SELA = 16'h8000;
   localparam logic [15:0] B_SELB = 16'h4000;
   localparam logic [15:0] B_IORD = 16'h2000;
   localparam logic [15:0] B_MRD  = 16'h1000;
   localparam logic [15:0] B_MWR  = 16'h0800;
   localparam logic [15:0] B_PCW  = 16'h0400;
   localparam logic [15:0] B_IRLD = 16'h0200;
   localparam logic [15:0] B_TRLD = 16'h0100;
   localparam logic [15:0] B_MDR  = 16'h0080;
   localparam logic [15:0] B_DI   = 16'h0040;
   localparam logic [15:0] B_CZN  = 16'h0020;
   localparam logic [15:0] B_RW   = 16'h0010;
   localparam logic [15:0] B_RA2  = 16'h0008;
   localparam logic [15:0] B_WA   = 16'h0004;
   localparam logic [15:0] B_WD   = 16'h0002;
   localparam logic [15:0] B_JMP  = 16'h0001;

   logic clk, rst, mem_ready;
   logic [IW-1:0] ins;
   logic [2:0] czn;
   logic selA, selB, IorD, memRead, memWrite, pcWrite, IRld, TRld, MDRld;
   logic DIld, CZNld, regWrite, RA2sel, WAsel, WDsel, jmpSignal, fault;
   logic [AOPW-1:0] aluOp;
   logic [3:0] state_o;
   logic [15:0] strb;

   int n_chk  = 0;
   int n_pass = 0;
   bit faulted = 0;

   mc_controller_p #(.IW(IW), .AOPW(AOPW), .WAIT_MAX(WM)) dut (
      .clk(clk), .rst(rst), .ins(ins), .czn(czn), .mem_ready(mem_ready),
      .selA(selA), .selB(selB), .IorD(IorD), .memRead(memRead),
      .memWrite(memWrite), .pcWrite(pcWrite), .IRld(IRld), .TRld(TRld),
      .MDRld(MDRld), .DIld(DIld), .CZNld(CZNld), .regWrite(regWrite),
      .RA2sel(RA2sel), .WAsel(WAsel), .WDsel(WDsel), .jmpSignal(jmpSignal),
      .aluOp(aluOp), .fault(fault), .state_o(state_o)
   );

   assign strb = {selA, selB, IorD, memRead, memWrite, pcWrite, IRld, TRld,
                  MDRld, DIld, CZNld, regWrite, RA2sel, WAsel, WDsel, jmpSignal};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // One clock: drive mem_ready, compare outputs mid-cycle, advance past the edge.
   task automatic cyc(input string tag, input int st, input logic [15:0] eb,
                      input int ealu, input bit ef, input bit rdy);
      mem_ready = rdy;
      @(negedge clk);
      chk({tag, "/state"}, 32'(state_o), 32'(st));
      chk({tag, "/strobes"}, 32'(strb), 32'(eb));
      chk({tag, "/aluOp"}, 32'(aluOp), 32'(ealu));
      chk({tag, "/fault"}, 32'(fault), 32'(ef));
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      for (int i = 0; i < n; i++) begin
         ins = IW'($urandom);
         czn = 3'($urandom);
         cyc("reset", 0, 16'h0, 0, 1'b0, 1'($urandom));
      end
      rst = 1'b0;
      faulted = 1'b0;
   endtask

   // A memory access stalled for w cycles; past WM stalled cycles it faults.
   task automatic mem_phase(input string tag, input int st, input logic [15:0] base,
                            input logic [15:0] done_bits, input int w);
      for (int k = 0; k <= w; k++) begin
         if (k < w) begin
            cyc({tag, "/wait"}, st, base, 0, 1'b0, 1'b0);
            if (WM > 0 && k == WM) begin
               faulted = 1'b1;
               return;
            end
         end else begin
            cyc({tag, "/done"}, st, base | done_bits, 0, 1'b0, 1'b1);
         end
      end
   endtask

   // Instruction-level model: fetch, decode, then the execution phases of the opcode.
   task automatic exec_instr(input logic [IW-1:0] iv, input logic [2:0] cv,
                             input int w_if, input int w_mem);
      logic [2:0] op;
      logic [1:0] f, cc;
      bit taken;
      int alu;
      ins = iv;
      czn = cv;
      op = iv[IW-1:IW-3];
      f  = iv[IW-3:IW-4];
      cc = iv[IW-4:IW-5];
      mem_phase("IF", 0, B_MRD, B_IRLD | B_PCW, w_if);
      if (faulted) return;
      cyc("ID", 1, (op == 3'd4 || op == 3'd5 || op == 3'd7) ? 16'h0 : B_TRLD,
          0, 1'b0, 1'($urandom));
      case (op)
         3'd0: begin
            mem_phase("LW1", 4, B_IORD | B_MRD, B_MDR, w_mem);
            if (faulted) return;
            cyc("LW2", 5, B_RA2 | B_WA | B_RW, 0, 1'b0, 1'($urandom));
         end
         3'd1: mem_phase("SW", 8, B_IORD | B_SELB | B_MWR, 16'h0, w_mem);
         3'd2, 3'd3: begin
            mem_phase("AD1", 6, B_IORD | B_MRD, B_MDR, w_mem);
            if (faulted) return;
            cyc("AD2", 7, B_RA2 | B_WA | B_WD | B_RW | B_CZN, (op == 3'd3) ? 1 : 0,
                1'b0, 1'($urandom));
         end
         3'd4, 3'd5: begin
            alu = (f == 2'd2) ? 1 : (f == 2'd3) ? 2 : 0;
            cyc("ACU", 3, B_SELB | B_WD | B_RW | B_CZN | ((f == 2'd0) ? B_SELA : 16'h0),
                alu, 1'b0, 1'($urandom));
         end
         3'd6: begin
            taken = (cc == 2'd0) || (cc == 2'd1 && cv[2]) ||
                    (cc == 2'd2 && cv[1]) || (cc == 2'd3 && cv[0]);
            cyc("JMP", 2, taken ? (B_JMP | B_PCW) : 16'h0, 0, 1'b0, 1'($urandom));
         end
         default: cyc("DI", 9, B_DI, 0, 1'b0, 1'($urandom));
      endcase
   endtask

   task automatic after_fault();
      repeat (2) cyc("FAULT", 15, 16'h0, 0, 1'b1, 1'($urandom));
      do_reset(1);
   endtask

   int wi, wm;

   initial begin
      rst = 1'b1;
      ins = '0;
      czn = '0;
      mem_ready = 1'b0;
      #1;

      // Reset then ACU add with zero wait.
      do_reset(2);
      exec_instr(8'b1001_0000, 3'b000, 0, 0);
      // Load with two stall cycles in LW1.
      exec_instr(8'b0000_0000, 3'b101, 0, 2);
      // Conditional jump on Z, taken then not taken.
      exec_instr(8'b1101_0000, 3'b010, 0, 0);
      exec_instr(8'b1101_0000, 3'b101, 0, 0);
      // Completion on the last permitted wait cycle.
      exec_instr(8'b0010_0000, 3'b000, WM, WM);
      exec_instr(8'b0110_0000, 3'b000, 1, WM);
      // Store that never completes: faults after WM+1 cycles.
      exec_instr(8'b0010_0000, 3'b000, 0, 20);
      if (!faulted) chk("sw_timeout_model", 0, 1);
      after_fault();
      exec_instr(8'b1110_0000, 3'b000, 0, 0);

      // Reset pulsed while AD1 is stalled.
      ins = 8'b0100_0000;
      cyc("rstAD/IF", 0, B_MRD | B_IRLD | B_PCW, 0, 1'b0, 1'b1);
      cyc("rstAD/ID", 1, B_TRLD, 0, 1'b0, 1'b0);
      cyc("rstAD/AD1", 6, B_IORD | B_MRD, 0, 1'b0, 1'b0);
      do_reset(1);
      exec_instr(8'b1011_0000, 3'b000, 0, 0);

      // Random instruction stream.
      for (int n = 0; n < 300; n++) begin
         wi = ($urandom_range(0, 15) == 0) ? $urandom_range(WM + 1, WM + 3) : $urandom_range(0, WM);
         wm = ($urandom_range(0, 15) == 0) ? $urandom_range(WM + 1, WM + 3) : $urandom_range(0, WM);
         exec_instr(IW'($urandom), 3'($urandom), wi, wm);
         if (faulted) after_fault();
         else if ($urandom_range(0, 40) == 0) do_reset(1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
